demux_83: RTL and testbench
===========================

// Module: demux_83
// PURPOSE
// - Registered 1-to-8 demultiplexer: routes data input y to one of eight outputs I0..I7,
//   selected by the 3-bit code {s1,s2,s3}.
// - All non-selected outputs are driven to 0.
// - Sits between a single-source data path and eight consumer lanes. The output stage is
//   registered so that downstream timing is clean.
// PARAMETERS
// - DATA_W  default 1  width of y and of each output I0..I7
// PORTS
// - clk     in   1       single clock; all state updates on the rising edge
// - rst     in   1       reset: synchronous, active-high
// - s1      in   1       select bit 2 (MSB)
// - s2      in   1       select bit 1
// - s3      in   1       select bit 0 (LSB)
// - enable  in   1       1 = route y to the selected output; 0 = demux disabled
// - y       in   DATA_W  data input
// - I0..I7  out  DATA_W  data outputs; index = {s1,s2,s3}
// BEHAVIOUR
// - Select index sel = {s1,s2,s3}, value 0..7. s1 is the MSB and s3 is the LSB.
// - Rising clk edge with rst=1:
//   - I0..I7 <= 0.
//   - rst has priority over every other input.
// - Rising clk edge with rst=0 and enable=1:
//   - I[sel] <= y.
//   - I[k] <= 0 for every k != sel.
// - Rising clk edge with rst=0 and enable=0:
//   - I0..I7 <= 0 (default build; see CONFIGURATION).
// - Latency: outputs reflect the inputs sampled at the previous rising edge, i.e. 1 cycle.
//   There is no combinational path from any input to any output.
// - Exactly one output may be nonzero at a time. A nonzero output always equals the y
//   sampled for that cycle.
// - Select changing every cycle:
//   - Each cycle's data goes only to that cycle's selected lane.
//   - The previously selected lane returns to 0 on the next edge.
// - y=0 while enabled: all outputs are 0. This is not an error case.
// - Reset asserted mid-stream clears the outputs on that edge. The first edge after rst
//   deasserts resumes normal routing.
// - X/Z on any select bit while enable=1 may propagate X to the outputs. No recovery logic.
// CONFIGURATION
// - Macro DEMUX_83_HOLD_EN.
// - Undefined (default): enable=0 clears all outputs to 0 on the next edge.
// - Defined: enable=0 holds all outputs at their current values. Select and y are ignored
//   while enable=0.
// - Either way, rst=1 clears the outputs to 0.
// STRUCTURE
// - Shared package demux_pkg:
//   - localparam NUM_OUT = 8
//   - localparam SEL_W = 3
//   - typedef logic [SEL_W-1:0] sel_t
// - Sub-module decode_3to8:
//   - Combinational.
//   - Inputs: sel_t sel, en. Output: 8-bit one-hot dec.
//   - dec = 0 when en=0.
// - Top level:
//   - Per-lane next value = dec[k] ? y : 0.
//   - Registered per lane with synchronous reset.
//   - Optional hold path under DEMUX_83_HOLD_EN.
// TESTING
// - Reset: rst=1 for 2 cycles with y=1, enable=1, sel=5 -> I0..I7 all 0 at both edges.
// - Full sweep: enable=1, y=1, sel stepped 0..7, one per cycle.
//   - One cycle later, only I[sel]=1 and the other seven are 0.
//   - Repeat with y=0 -> all outputs 0.
// - Enable low: enable=0, y=1, sel=3.
//   - Default build: all outputs 0.
//   - DEMUX_83_HOLD_EN build: I3 stays at its prior value 1 and the others stay 0.
// - Back-to-back select change: sel=2 then sel=6 with y=1.
//   - I2=1 at edge n+1.
//   - At edge n+2: I2=0 and I6=1.
// - Mid-stream reset: routing sel=7 with y=1, assert rst for 1 cycle.
//   - I7=0 at that edge.
//   - Routing resumes at the first edge after deassertion.
// - Bus width: DATA_W=4, y=4'hA, sel=4, enable=1.
//   - I4=4'hA after 1 cycle; every other output = 4'h0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 registered demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_OUT = 8;
  localparam int unsigned SEL_W   = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : demux_pkg

// File: rtl/demux_83_decode_3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module decode_3to8
  import demux_pkg::*;
(
  input  sel_t               sel,
  input  logic               en,
  output logic [NUM_OUT-1:0] dec
);

  // One-hot decode of sel, gated by en
  always_comb begin
    dec = '0;
    if (en) begin
      dec[sel] = 1'b1;
    end
  end

endmodule : decode_3to8

// File: rtl/demux_83.sv
// Registered 1-to-8 demultiplexer: y is routed to lane {s1,s2,s3}, other lanes are 0.
// Optional build macro DEMUX_83_HOLD_EN: when defined, enable=0 holds the lanes
// instead of clearing them.
module demux_83
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s1,
  input  logic              s2,
  input  logic              s3,
  input  logic              enable,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] I0,
  output logic [DATA_W-1:0] I1,
  output logic [DATA_W-1:0] I2,
  output logic [DATA_W-1:0] I3,
  output logic [DATA_W-1:0] I4,
  output logic [DATA_W-1:0] I5,
  output logic [DATA_W-1:0] I6,
  output logic [DATA_W-1:0] I7
);

  sel_t               sel;
  logic [NUM_OUT-1:0] dec_c;
  logic [DATA_W-1:0]  lane_d [NUM_OUT];
  logic [DATA_W-1:0]  lane_q [NUM_OUT];

  assign sel = {s1, s2, s3};

  decode_3to8 u_decode (
    .sel (sel),
    .en  (enable),
    .dec (dec_c)
  );

  // Next lane values: selected lane takes y, all others go to zero
  always_comb begin
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      lane_d[k] = dec_c[k] ? y : '0;
`ifdef DEMUX_83_HOLD_EN
      if (!enable) begin
        lane_d[k] = lane_q[k];
      end
`endif
    end
  end

  // Output lane registers with synchronous reset
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (rst) begin
        lane_q[k] <= '0;
      end else begin
        lane_q[k] <= lane_d[k];
      end
    end
  end

  assign I0 = lane_q[0];
  assign I1 = lane_q[1];
  assign I2 = lane_q[2];
  assign I3 = lane_q[3];
  assign I4 = lane_q[4];
  assign I5 = lane_q[5];
  assign I6 = lane_q[6];
  assign I7 = lane_q[7];

endmodule : demux_83

// File: tb/tb_demux_83.sv
// Self-checking bench for demux_83 (DATA_W=4), default and DEMUX_83_HOLD_EN builds.
module tb_demux_83;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         s1, s2, s3;
  logic         enable;
  logic [W-1:0] y;
  logic [W-1:0] I0, I1, I2, I3, I4, I5, I6, I7;

  logic [8*W-1:0] obs_v;
  logic [8*W-1:0] exp_v;
  int total;
  int bad;

  demux_83 #(.DATA_W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .s1     (s1),
    .s2     (s2),
    .s3     (s3),
    .enable (enable),
    .y      (y),
    .I0     (I0),
    .I1     (I1),
    .I2     (I2),
    .I3     (I3),
    .I4     (I4),
    .I5     (I5),
    .I6     (I6),
    .I7     (I7)
  );

  assign obs_v = {I7, I6, I5, I4, I3, I2, I1, I0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, wait for the edge, then advance the reference model.
  task automatic cycle(input logic r, input logic e, input logic [2:0] s,
                       input logic [W-1:0] d);
    rst    = r;
    enable = e;
    {s1, s2, s3} = s;
    y      = d;
    @(posedge clk);
    #1;
    if (r) begin
      exp_v = '0;
    end else if (e) begin
      exp_v = (8*W)'(d) << (W * int'(s));
    end else begin
`ifdef DEMUX_83_HOLD_EN
      exp_v = exp_v;
`else
      exp_v = '0;
`endif
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 3'd5, 4'h1);
      total++;
      if (obs_v !== 32'h0) begin
        bad++;
        $display("FAIL reset_edge%0d: got %h want %h", i, obs_v, 32'h0);
      end
    end
  endtask

  task automatic test_sweep(input logic [W-1:0] d);
    for (int s = 0; s < 8; s++) begin
      cycle(1'b0, 1'b1, 3'(s), d);
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL sweep_y%0h_sel%0d: got %h want %h", d, s, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_enable_low();
    cycle(1'b0, 1'b1, 3'd3, 4'h1);
    cycle(1'b0, 1'b0, 3'd3, 4'h1);
    total++;
`ifdef DEMUX_83_HOLD_EN
    if (obs_v !== 32'h0000_1000) begin
      bad++;
      $display("FAIL enable_low_hold: got %h want %h", obs_v, 32'h0000_1000);
    end
`else
    if (obs_v !== 32'h0) begin
      bad++;
      $display("FAIL enable_low_clear: got %h want %h", obs_v, 32'h0);
    end
`endif
    // different select and data while disabled must not disturb the lanes
    cycle(1'b0, 1'b0, 3'd6, 4'hF);
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("FAIL enable_low_ignore: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 3'd2, 4'h1);
    total++;
    if (I2 !== 4'h1 || obs_v !== exp_v) begin
      bad++;
      $display("FAIL b2b_first: got %h want %h", obs_v, exp_v);
    end
    cycle(1'b0, 1'b1, 3'd6, 4'h1);
    total++;
    if (I2 !== 4'h0 || I6 !== 4'h1 || obs_v !== exp_v) begin
      bad++;
      $display("FAIL b2b_second: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b0, 1'b1, 3'd7, 4'h1);
    total++;
    if (I7 !== 4'h1) begin
      bad++;
      $display("FAIL midrst_before: got I7=%h want %h", I7, 4'h1);
    end
    cycle(1'b1, 1'b1, 3'd7, 4'h1);
    total++;
    if (obs_v !== 32'h0) begin
      bad++;
      $display("FAIL midrst_edge: got %h want %h", obs_v, 32'h0);
    end
    cycle(1'b0, 1'b1, 3'd7, 4'h1);
    total++;
    if (obs_v !== 32'h1000_0000) begin
      bad++;
      $display("FAIL midrst_resume: got %h want %h", obs_v, 32'h1000_0000);
    end
  endtask

  task automatic test_bus_width();
    cycle(1'b0, 1'b1, 3'd4, 4'hA);
    total++;
    if (obs_v !== 32'h000A_0000) begin
      bad++;
      $display("FAIL bus_width: got %h want %h", obs_v, 32'h000A_0000);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(15) == 0), ($urandom_range(3) != 0),
            3'($urandom_range(7)), 4'($urandom));
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL random_%0d: got %h want %h", i, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    exp_v  = '0;
    rst    = 1'b1;
    enable = 1'b0;
    {s1, s2, s3} = 3'd0;
    y      = '0;
    test_reset();
    test_sweep(4'h1);
    test_sweep(4'h0);
    test_enable_low();
    test_back_to_back();
    test_mid_reset();
    test_bus_width();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux_83
